// File: rtl/p_weight_update.sv
// Perceptron weight-update stage: accepts one signed error sample with its
// input vector, then walks the weight bank one weight per cycle applying
// w[i] += (err * x[i]) >>> (W_FRAC + LR_SHIFT) with saturation.
// The stored weight bank also feeds the forward datapath through w_out.
module p_weight_update #(
  parameter  int N        = 4,
  parameter  int W_PREC   = 16,
  parameter  int W_FRAC   = 8,
  parameter  int LR_SHIFT = 4,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       err_valid,
  output logic                       err_ready,
  input  logic signed [W_PREC-1:0]   err,
  input  logic                       err_ovf,
  input  logic [N*W_PREC-1:0]        x_in,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [W_PREC-1:0]          wr_data,
  output logic [N*W_PREC-1:0]        w_out,
  output logic                       busy,
  output logic                       done,
  output logic                       sat
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int SHIFT = W_FRAC + LR_SHIFT;
  localparam logic signed [2*W_PREC:0] W_MAX = {{(W_PREC+2){1'b0}}, {(W_PREC-1){1'b1}}};
  localparam logic signed [2*W_PREC:0] W_MIN = {{(W_PREC+2){1'b1}}, {(W_PREC-1){1'b0}}};

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q;
  logic                       sat_q;
  logic signed [W_PREC-1:0]   err_q;
  logic signed [W_PREC-1:0]   x_q [N];
  logic signed [W_PREC-1:0]   w_q [N];

  logic                       accept, wr_hit, last_idx;
  logic signed [2*W_PREC-1:0] prod, delta;
  logic signed [2*W_PREC:0]   sum;
  logic signed [W_PREC-1:0]   w_d;
  logic                       ovr_d;

  // Clamp a wide sum into the signed weight range.
  function automatic logic signed [W_PREC-1:0] saturate(input logic signed [2*W_PREC:0] s);
    if (s > W_MAX)      return {1'b0, {(W_PREC-1){1'b1}}};
    else if (s < W_MIN) return {1'b1, {(W_PREC-1){1'b0}}};
    else                return s[W_PREC-1:0];
  endfunction

  assign err_ready = (state_q == IDLE) && !wr_en;
  assign accept    = err_valid && err_ready;
  assign wr_hit    = (state_q == IDLE) && wr_en && (32'(wr_idx) < N);
  assign last_idx  = (idx_q == IDX_W'(N - 1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sat       = sat_q;

  // Update arithmetic for the weight currently addressed by idx_q.
  always_comb begin
    prod  = err_q * x_q[idx_q];
    delta = prod >>> SHIFT;
    sum   = $signed({w_q[idx_q][W_PREC-1], {W_PREC{w_q[idx_q][W_PREC-1]}}, w_q[idx_q]})
          + $signed({delta[2*W_PREC-1], delta});
    ovr_d = (sum > W_MAX) || (sum < W_MIN);
    w_d   = saturate(sum);
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, weight index and sticky saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
        sat_q <= err_ovf;
      end else if (state_q == CALC) begin
        idx_q <= last_idx ? '0 : idx_q + 1'b1;
        if (ovr_d) sat_q <= 1'b1;
      end
    end
  end

  // Sample capture on accept; later input changes do not disturb the update.
  always_ff @(posedge clk) begin
    if (accept) begin
      err_q <= err;
      for (int i = 0; i < N; i++) x_q[i] <= x_in[i*W_PREC +: W_PREC];
    end
  end

  // Weight bank: cleared by reset, preloaded in IDLE, updated one per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else if (wr_hit) begin
      w_q[wr_idx] <= wr_data;
    end else if (state_q == CALC) begin
      w_q[idx_q] <= w_d;
    end
  end

  // Pack the stored weights onto the output bus.
  always_comb begin
    w_out = '0;
    for (int i = 0; i < N; i++) w_out[i*W_PREC +: W_PREC] = w_q[i];
  end

endmodule

// File: tb/tb_p_weight_update.sv
module tb_p_weight_update;
  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             err_valid;
  logic             err_ready;
  logic [W-1:0]     err;
  logic             err_ovf;
  logic [N*W-1:0]   x_in;
  logic             wr_en;
  logic [1:0]       wr_idx;
  logic [W-1:0]     wr_data;
  logic [N*W-1:0]   w_out;
  logic             busy, done, sat;

  int n_vec = 0;
  int n_err = 0;

  p_weight_update #(.N(N), .W_PREC(W), .W_FRAC(8), .LR_SHIFT(4)) dut (
    .clk(clk), .reset(reset), .err_valid(err_valid), .err_ready(err_ready),
    .err(err), .err_ovf(err_ovf), .x_in(x_in), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .w_out(w_out), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic preload(input logic [1:0] idx, input logic [W-1:0] val);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_data = val;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic preload_all(input logic [W-1:0] v0, v1, v2, v3);
    preload(2'd0, v0); preload(2'd1, v1); preload(2'd2, v2); preload(2'd3, v3);
  endtask

  // Present one sample, wait (bounded) for done, return in IDLE.
  task automatic run_sample(input logic [W-1:0] e, input logic ovf,
                            input logic [N*W-1:0] x, output bit got_done);
    got_done = 1'b0;
    @(negedge clk);
    err_valid = 1'b1; err = e; err_ovf = ovf; x_in = x;
    @(negedge clk);
    err_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin got_done = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    err_valid = 1'b0; err = '0; err_ovf = 1'b0; x_in = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (w_out !== '0) begin n_err++; $display("FAIL reset_w got=%h exp=0", w_out); end
    n_vec++; if ({busy, done, sat} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {busy, done, sat}); end
    n_vec++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", err_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [N*W-1:0] exp_w;
    preload_all(16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    err_valid = 1'b1; err = 16'h0100; err_ovf = 1'b0;
    x_in = {16'h0000, 16'hFF00, 16'h0100, 16'h0200};
    @(negedge clk);   // accept edge T has passed
    err_valid = 1'b0;
    for (int k = 0; k <= N; k++) begin
      n_vec++; if (err_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_low k=%0d got=%b exp=0", k, err_ready); end
      n_vec++; if (done !== (k == N)) begin n_err++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, (k == N)); end
      @(negedge clk);
    end
    n_vec++; if ({err_ready, done, busy} !== 3'b100) begin n_err++; $display("FAIL basic_idle got=%b exp=100", {err_ready, done, busy}); end
    exp_w = {16'h0000, 16'hFFF0, 16'h0010, 16'h0020};
    n_vec++; if (w_out !== exp_w) begin n_err++; $display("FAIL basic_w got=%h exp=%h", w_out, exp_w); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL basic_sat got=%b exp=0", sat); end
  endtask

  task automatic test_saturation;
    bit ok;
    logic [N*W-1:0] exp_w;
    preload(2'd0, 16'h7F00);
    run_sample(16'h7FFF, 1'b0, {16'h0, 16'h0, 16'h0, 16'h7FFF}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL satpos_timeout got=0 exp=1"); end
    exp_w = {16'h0000, 16'hFFF0, 16'h0010, 16'h7FFF};
    n_vec++; if (w_out !== exp_w) begin n_err++; $display("FAIL satpos_w got=%h exp=%h", w_out, exp_w); end
    n_vec++; if (sat !== 1'b1) begin n_err++; $display("FAIL satpos_sat got=%b exp=1", sat); end
    preload(2'd0, 16'h8100);
    run_sample(16'h8000, 1'b0, {16'h0, 16'h0, 16'h0, 16'h7FFF}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL satneg_timeout got=0 exp=1"); end
    n_vec++; if (w_out[15:0] !== 16'h8000) begin n_err++; $display("FAIL satneg_w0 got=%h exp=8000", w_out[15:0]); end
    n_vec++; if (sat !== 1'b1) begin n_err++; $display("FAIL satneg_sat got=%b exp=1", sat); end
  endtask

  task automatic test_floor;
    bit ok;
    preload_all(16'h0, 16'h0, 16'h0, 16'h0);
    run_sample(16'hFF00, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0001}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL floorneg_timeout got=0 exp=1"); end
    n_vec++; if (w_out[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL floorneg_w0 got=%h exp=FFFF", w_out[15:0]); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL floorneg_sat got=%b exp=0", sat); end
    preload(2'd0, 16'h0);
    run_sample(16'h0100, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0001}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL floorpos_timeout got=0 exp=1"); end
    n_vec++; if (w_out[15:0] !== 16'h0000) begin n_err++; $display("FAIL floorpos_w0 got=%h exp=0000", w_out[15:0]); end
  endtask

  task automatic test_handshake;
    bit ok;
    logic [N*W-1:0] exp_w;
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 16'h1234;
    err_valid = 1'b1; err = 16'h0100; err_ovf = 1'b0;
    x_in = {16'h0, 16'h0, 16'h0, 16'h0100};
    #1;
    n_vec++; if (err_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_wr got=%b exp=0", err_ready); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_no_accept got=%b exp=0", busy); end
    n_vec++; if (w_out[47:32] !== 16'h1234) begin n_err++; $display("FAIL hs_write got=%h exp=1234", w_out[47:32]); end
    wr_en = 1'b0;
    #1;
    n_vec++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready got=%b exp=1", err_ready); end
    @(negedge clk);
    err_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL hs_accept got=%b exp=1", busy); end
    x_in = {4{16'h7FFF}}; err = 16'h0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_vec++; if (!ok) begin n_err++; $display("FAIL hs_timeout got=0 exp=1"); end
    exp_w = {16'h0000, 16'h1234, 16'h0000, 16'h0010};
    n_vec++; if (w_out !== exp_w) begin n_err++; $display("FAIL hs_captured_w got=%h exp=%h", w_out, exp_w); end
  endtask

  task automatic test_ovf;
    bit ok;
    logic [N*W-1:0] exp_w;
    exp_w = {16'h0000, 16'h1234, 16'h0000, 16'h0010};
    run_sample(16'h0000, 1'b1, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout got=0 exp=1"); end
    n_vec++; if (w_out !== exp_w) begin n_err++; $display("FAIL ovf_w got=%h exp=%h", w_out, exp_w); end
    n_vec++; if (sat !== 1'b1) begin n_err++; $display("FAIL ovf_sat got=%b exp=1", sat); end
    run_sample(16'h0100, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0100}, ok);
    exp_w = {16'h0000, 16'h1234, 16'h0000, 16'h0020};
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf2_timeout got=0 exp=1"); end
    n_vec++; if (w_out !== exp_w) begin n_err++; $display("FAIL ovf2_w got=%h exp=%h", w_out, exp_w); end
    n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL ovf2_sat got=%b exp=0", sat); end
  endtask

  task automatic test_midreset;
    bit ok;
    @(negedge clk);
    err_valid = 1'b1; err = 16'h0100; err_ovf = 1'b1;
    x_in = {4{16'h0100}};
    @(posedge clk);   // edge T: accept
    @(negedge clk);
    err_valid = 1'b0;
    repeat (2) @(posedge clk);   // edge T+2
    #1 reset = 1'b1;
    #1;
    n_vec++; if (w_out !== '0) begin n_err++; $display("FAIL mid_w got=%h exp=0", w_out); end
    n_vec++; if ({busy, done, sat} !== 3'b000) begin n_err++; $display("FAIL mid_flags got=%b exp=000", {busy, done, sat}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", err_ready); end
    run_sample(16'h0100, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0200}, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_timeout got=0 exp=1"); end
    n_vec++; if (w_out !== 64'h0000_0000_0000_0020) begin n_err++; $display("FAIL mid_after_w got=%h exp=0000000000000020", w_out); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_floor;
    test_handshake;
    test_ovf;
    test_midreset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
